watch_cnt_gen: RTL and testbench

//  Parametrised stopwatch/countdown core: chain of NDIG BCD digits (mod-10 or mod-6 per digit) on a

---
 rtl/watch_pkg.sv | 18 +
 rtl/watch_digit.sv | 51 +++++
 rtl/watch_cnt_gen.sv | 188 ++++++++++++++++++
 tb/tb_watch_cnt_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch_cnt_gen stopwatch/countdown core.
package watch_pkg;

    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Maximum value of digit i: 5 for mod-6 slots, 9 for mod-10 slots.
    function automatic logic [DIG_W-1:0] digit_max(input logic [31:0] mask, input int unsigned i);
        return (((mask >> i) & 32'd1) != 32'd0) ? DIG_W'(5) : DIG_W'(9);
    endfunction

endpackage

// File: rtl/watch_digit.sv
// One BCD digit of the synchronous carry chain: up/down step, clear, clamped preset load.
module watch_digit
    import watch_pkg::*;
#(
    parameter int unsigned MOD = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             dir,
    input  logic [DIG_W-1:0] preset,
    output logic [DIG_W-1:0] q,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [DIG_W-1:0] MAXV = DIG_W'(MOD - 1);

    logic [DIG_W-1:0] q_q;
    logic [DIG_W-1:0] q_d;

    assign at_max  = (q_q == MAXV);
    assign at_zero = (q_q == '0);
    assign q       = q_q;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = (preset > MAXV) ? MAXV : preset;
        end else if (step) begin
            if (dir) begin
                q_d = at_zero ? MAXV : (q_q - DIG_W'(1));
            end else begin
                q_d = at_max ? '0 : (q_q + DIG_W'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/watch_cnt_gen.sv
// Stopwatch/countdown core: NDIG BCD digits on one synchronous carry chain, run/pause/done FSM.
// Optional display lap-hold is enabled by defining LAP_HOLD_EN.
module watch_cnt_gen
    import watch_pkg::*;
#(
    parameter int unsigned     NDIG      = 7,
    parameter int unsigned     DISP_DIG  = 6,
    parameter logic [NDIG-1:0] MOD6_MASK = 7'b1010000,
    parameter int unsigned     PRESCALE  = 1
) (
    input  logic                      clk_1Khz,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      dir,
    input  logic [DIG_W*NDIG-1:0]     preset,
    input  logic                      lap,
    output logic [DIG_W*NDIG-1:0]     count,
    output logic [DIG_W*DISP_DIG-1:0] dispbuf,
    output logic                      running,
    output logic                      done,
    output logic                      wrap
);

    localparam int unsigned   CW      = DIG_W * NDIG;
    localparam int unsigned   DW      = DIG_W * DISP_DIG;
    localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;
    logic          running_q;

    logic [NDIG-1:0] at_max_c;
    logic [NDIG-1:0] at_zero_c;
    logic [NDIG-1:0] step_c;
    logic [NDIG:0]   up_all_c;
    logic [NDIG:0]   dn_all_c;
    logic            tick_c;
    logic            cnt_en_c;
    logic            all_zero_c;
    logic            last_c;
    logic [DW-1:0]   live_c;

    assign tick_c     = (state_q == ST_RUN) && (presc_q == PS_LAST);
    assign all_zero_c = (count == CW'(0));
    assign last_c     = (count[DIG_W-1:0] == DIG_W'(1)) && ((count >> DIG_W) == CW'(0));
    // Commands pre-empt the tick; a down tick at zero is never allowed to underflow.
    assign cnt_en_c   = tick_c && !clear && !load && !pause && !(dir_q && all_zero_c);
    assign live_c     = count[CW-1 -: DW];

    always_comb begin
        up_all_c    = '0;
        dn_all_c    = '0;
        step_c      = '0;
        up_all_c[0] = 1'b1;
        dn_all_c[0] = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            up_all_c[i+1] = up_all_c[i] & at_max_c[i];
            dn_all_c[i+1] = dn_all_c[i] & at_zero_c[i];
            step_c[i]     = cnt_en_c & (dir_q ? dn_all_c[i] : up_all_c[i]);
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        localparam int unsigned MODV = (digit_max(32'(MOD6_MASK), g) == DIG_W'(5)) ? 6 : 10;

        watch_digit #(
            .MOD(MODV)
        ) u_digit (
            .clk    (clk_1Khz),
            .rst_n  (rst),
            .clear  (clear),
            .load   (load & ~clear),
            .step   (step_c[g]),
            .dir    (dir_q),
            .preset (preset[g*DIG_W +: DIG_W]),
            .q      (count[g*DIG_W +: DIG_W]),
            .at_max (at_max_c[g]),
            .at_zero(at_zero_c[g])
        );
    end

    // Next-state logic; commands are prioritised clear > load > pause > start.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear || load) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (pause) begin
            presc_d = '0;
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start && (state_q != ST_RUN)) begin
            dir_d   = dir;
            presc_d = '0;
            if (dir && all_zero_c) begin
                state_d = ST_DONE;
                done_d  = (state_q != ST_DONE);
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN) begin
            if (tick_c) begin
                presc_d = '0;
                if (dir_q) begin
                    if (last_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else if (up_all_c[NDIG]) begin
                    wrap_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign wrap    = wrap_q;

`ifdef LAP_HOLD_EN
    logic          hold_q, hold_d;
    logic [DW-1:0] held_q, held_d;

    // Lap toggles a frozen copy of the display while the count keeps running.
    always_comb begin
        hold_d = hold_q;
        held_d = held_q;
        if (clear || load) begin
            hold_d = 1'b0;
        end else if (lap && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) begin
            hold_d = !hold_q;
            if (!hold_q) begin
                held_d = live_c;
            end
        end
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            hold_q <= 1'b0;
            held_q <= '0;
        end else begin
            hold_q <= hold_d;
            held_q <= held_d;
        end
    end

    assign dispbuf = hold_q ? held_q : live_c;
`else
    logic lap_unused_c;

    assign lap_unused_c = lap;
    assign dispbuf      = live_c;
`endif

endmodule

// File: tb/tb_watch_cnt_gen.sv
// Self-checking bench for watch_cnt_gen: directed sequences, clamp table and random commands
// checked against a mixed-radix integer model of the count.
module tb_watch_cnt_gen;

    localparam int NDIG     = 7;
    localparam int DISP_DIG = 6;
    localparam int CW       = 4 * NDIG;
    localparam int DW       = 4 * DISP_DIG;
    localparam int PRESCALE = 1;
    localparam logic [6:0] MASK = 7'b1010000;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    typedef struct packed {
        logic [CW-1:0] pre;
        logic [CW-1:0] exp;
    } clamp_vec_t;

    logic          clk = 1'b0;
    logic          rst, start, pause, clear, load, dir, lap;
    logic [CW-1:0] preset;
    logic [CW-1:0] count;
    logic [DW-1:0] dispbuf;
    logic          running, done, wrap;

    int total = 0;
    int bad   = 0;

    // model state
    int            m_st, m_dir, m_val, m_ps, m_hold, m_done, m_wrap, m_total;
    logic [DW-1:0] m_held;

    watch_cnt_gen #(
        .NDIG(NDIG), .DISP_DIG(DISP_DIG), .MOD6_MASK(MASK), .PRESCALE(PRESCALE)
    ) dut (
        .clk_1Khz(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .load(load), .dir(dir), .preset(preset), .lap(lap), .count(count),
        .dispbuf(dispbuf), .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int mod_of(input int i);
        return (((MASK >> i) & 7'd1) != 7'd0) ? 6 : 10;
    endfunction

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(x % mod_of(i));
            x = x / mod_of(i);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] live_of(input int v);
        logic [CW-1:0] b;
        b = to_bcd(v);
        return b[CW-1 -: DW];
    endfunction

    function automatic int clamp_val(input logic [CW-1:0] p);
        int v, w, d;
        v = 0;
        w = 1;
        for (int i = 0; i < NDIG; i++) begin
            d = int'(p[i*4 +: 4]);
            if (d >= mod_of(i)) d = mod_of(i) - 1;
            v = v + d * w;
            w = w * mod_of(i);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_dir = 0; m_val = 0; m_ps = 0;
        m_hold = 0; m_held = '0; m_done = 0; m_wrap = 0;
    endtask

    // One clock edge of the specified behaviour, applied to the current inputs.
    task automatic model_edge();
        int pst, pval;
        pst = m_st;
        pval = m_val;
        m_done = 0;
        m_wrap = 0;
        if (clear) begin
            m_val = 0; m_st = S_IDLE; m_ps = 0; m_hold = 0;
        end else if (load) begin
            m_val = clamp_val(preset); m_st = S_IDLE; m_ps = 0; m_hold = 0;
        end else if (pause) begin
            m_ps = 0;
            if (m_st == S_RUN) m_st = S_PAUSE;
        end else if (start && m_st != S_RUN) begin
            m_dir = int'(dir);
            m_ps = 0;
            if (dir && m_val == 0) begin
                if (m_st != S_DONE) m_done = 1;
                m_st = S_DONE;
            end else begin
                m_st = S_RUN;
            end
        end else if (m_st == S_RUN) begin
            if (m_ps == PRESCALE - 1) begin
                m_ps = 0;
                if (m_dir == 0) begin
                    if (m_val == m_total - 1) begin
                        m_val = 0;
                        m_wrap = 1;
                    end else begin
                        m_val = m_val + 1;
                    end
                end else begin
                    m_val = m_val - 1;
                    if (m_val == 0) begin
                        m_done = 1;
                        m_st = S_DONE;
                    end
                end
            end else begin
                m_ps = m_ps + 1;
            end
        end
`ifdef LAP_HOLD_EN
        if (!clear && !load && lap && (pst == S_RUN || pst == S_PAUSE)) begin
            if (m_hold != 0) begin
                m_hold = 0;
            end else begin
                m_hold = 1;
                m_held = live_of(pval);
            end
        end
`endif
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] exp_disp;
        exp_disp = (m_hold != 0) ? m_held : live_of(m_val);
        chk({tag, ".count"},   32'(count),   32'(to_bcd(m_val)));
        chk({tag, ".dispbuf"}, 32'(dispbuf), 32'(exp_disp));
        chk({tag, ".running"}, 32'(running), (m_st == S_RUN) ? 32'd1 : 32'd0);
        chk({tag, ".done"},    32'(done),    32'(m_done));
        chk({tag, ".wrap"},    32'(wrap),    32'(m_wrap));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0;
    endtask

    initial begin
        clamp_vec_t vecs [4];
        int r, mode, d;

        vecs[0] = '{pre: 28'h00C000F, exp: 28'h0050009};
        vecs[1] = '{pre: 28'hFFFFFFF, exp: 28'h5959999};
        vecs[2] = '{pre: 28'h1234567, exp: 28'h1234567};
        vecs[3] = '{pre: 28'h7A6B0C9, exp: 28'h5959099};

        m_total = 1;
        for (int i = 0; i < NDIG; i++) m_total = m_total * mod_of(i);

        rst = 1'b0; dir = 1'b0; preset = '0;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        chk("reset.count0", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // up count for one second
        start = 1'b1; cycle("start_up"); start = 1'b0;
        repeat (1000) cycle("up");
        chk("up1000.count", 32'(count), 32'h0001000);
        chk("up1000.running", 32'(running), 32'd1);

        // rollover from all-max
        load = 1'b1; preset = 28'h5959999; cycle("ld_max"); load = 1'b0;
        start = 1'b1; cycle("start_max"); start = 1'b0;
        cycle("rollover");
        chk("rollover.count", 32'(count), 32'd0);
        chk("rollover.wrap", 32'(wrap), 32'd1);
        chk("rollover.running", 32'(running), 32'd1);
        cycle("post_roll");

        // countdown to terminal zero
        load = 1'b1; preset = 28'h0000003; cycle("ld3"); load = 1'b0;
        dir = 1'b1; start = 1'b1; cycle("start_dn"); start = 1'b0;
        cycle("dn2"); cycle("dn1"); cycle("dn0");
        chk("dn0.count", 32'(count), 32'd0);
        chk("dn0.done", 32'(done), 32'd1);
        chk("dn0.running", 32'(running), 32'd0);
        cycle("dn_hold");
        chk("dn_hold.done", 32'(done), 32'd0);

        // clamped preset loads
        for (int k = 0; k < 4; k++) begin
            load = 1'b1; preset = vecs[k].pre; cycle("clamp"); load = 1'b0;
            chk("clamp.count", 32'(count), 32'(vecs[k].exp));
        end

        // pause at 1.234 and resume
        clear = 1'b1; cycle("clr"); clear = 1'b0;
        dir = 1'b0; start = 1'b1; cycle("start_p"); start = 1'b0;
        repeat (1234) cycle("run_p");
        chk("pre_pause.count", 32'(count), 32'h0001234);
        pause = 1'b1; cycle("pause"); pause = 1'b0;
        repeat (50) cycle("paused");
        chk("paused.count", 32'(count), 32'h0001234);
        chk("paused.running", 32'(running), 32'd0);
        start = 1'b1; cycle("resume"); start = 1'b0;
        chk("resume.count", 32'(count), 32'h0001234);
        cycle("resume1");
        chk("resume1.count", 32'(count), 32'h0001235);

        // load on the same edge as a wrapping tick
        load = 1'b1; preset = 28'h5959998; cycle("ld998"); load = 1'b0;
        start = 1'b1; cycle("st998"); start = 1'b0;
        cycle("at999");
        load = 1'b1; preset = 28'h0000042; cycle("ld_tick"); load = 1'b0;
        chk("ld_tick.count", 32'(count), 32'h0000042);
        chk("ld_tick.wrap", 32'(wrap), 32'd0);

        // start counting down from zero
        clear = 1'b1; cycle("clr0"); clear = 1'b0;
        dir = 1'b1; start = 1'b1; cycle("start_z");
        chk("start_z.done", 32'(done), 32'd1);
        chk("start_z.running", 32'(running), 32'd0);
        cycle("start_z2"); start = 1'b0;
        chk("start_z2.done", 32'(done), 32'd0);

        // lap hold
        clear = 1'b1; cycle("clr_lap"); clear = 1'b0;
        dir = 1'b0; start = 1'b1; cycle("start_lap"); start = 1'b0;
        repeat (2000) cycle("run_lap");
        lap = 1'b1; cycle("lap1"); lap = 1'b0;
        repeat (499) cycle("lap_run");
        chk("lap_run.count", 32'(count), 32'h0002500);
`ifdef LAP_HOLD_EN
        chk("lap_run.dispbuf", 32'(dispbuf), 32'h000200);
`else
        chk("lap_run.dispbuf", 32'(dispbuf), 32'h000250);
`endif
        lap = 1'b1; cycle("lap2"); lap = 1'b0;
        chk("lap2.dispbuf", 32'(dispbuf), 32'h000250);

        // asynchronous reset mid-run
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.dispbuf", 32'(dispbuf), 32'd0);
        chk("async_rst.running", 32'(running), 32'd0);
        chk("async_rst.done", 32'(done), 32'd0);
        chk("async_rst.wrap", 32'(wrap), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // random command stream
        for (int n = 0; n < 4000; n++) begin
            idle_inputs();
            r = int'($urandom_range(0, 99));
            clear = (r < 2);
            load  = (r >= 2 && r < 6);
            pause = (r >= 6 && r < 10);
            start = (r >= 10 && r < 18);
            if (r >= 96) begin
                clear = 1'($urandom_range(0, 1));
                load  = 1'($urandom_range(0, 1));
                pause = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end
            lap = ($urandom_range(0, 24) == 0);
            dir = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            for (int i = 0; i < NDIG; i++) begin
                case (mode)
                    0:       d = int'($urandom_range(0, 15));
                    1:       d = (i == 0) ? int'($urandom_range(0, 9)) :
                                 ((i == 1) ? int'($urandom_range(0, 1)) : 0);
                    default: d = (i == 0) ? int'($urandom_range(0, 9)) : mod_of(i) - 1;
                endcase
                preset[i*4 +: 4] = 4'(d);
            end
            cycle("rand");
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
